pe_load_scheduler: RTL and testbench
====================================

// Module: pe_load_scheduler
// PURPOSE
//  Sequences operand loading and compute start for one PE, downstream of the packet depacketizer.
//  Accepts depacketized fields (timestep, ifmapb_filter, filter_row, data) via valid/ready.
//  Steers rows into the filter buffer or one of two timestep-indexed ifmap banks.
//  Fires the MAC array once filter and ifmap rows for the expected timestep are complete; double-buffers ifmap across timesteps.
// PARAMETERS
//  FILTER_WIDTH  8  bits per element; a row is 3 elements = 3*FILTER_WIDTH bits
//  CNT_W         8  width of completed-timestep counter
// PORTS
//  clk               in   1         single clock, rising edge
//  rst_n             in   1         asynchronous active-low reset
//  in_valid          in   1         depacketized row valid
//  in_ready          out  1         scheduler can accept row (combinational)
//  in_timestep       in   1         ifmap bank / timestep select
//  in_ifmapb_filter  in   1         1 = filter row, 0 = ifmap row
//  in_filter_row     in   2         row index 0..2; 3 illegal
//  in_data           in   3*FW      row payload
//  cfg_filter_clear  in   1         pulse: invalidate loaded filter
//  filt_we           out  1         filter buffer write strobe
//  filt_waddr        out  2         filter row address
//  ifmap_we          out  1         ifmap buffer write strobe
//  ifmap_wbank       out  1         ifmap bank (= timestep)
//  ifmap_waddr       out  2         ifmap row address
//  wdata             out  3*FW      shared write data
//  mac_start         out  1         one-cycle compute start
//  mac_ts            out  1         bank the MAC must read
//  mac_done          in   1         one-cycle compute complete
//  done_cnt          out  CNT_W     completed timesteps, wraps
//  err               out  3         sticky {done_spurious, dup_row, bad_row}
// BEHAVIOUR
//  - Reset: all outputs 0; masks 0; exp_ts=0; state IDLE; pending clear 0.
//  - Accept = in_valid & in_ready; next edge samples the fields.
//  - in_ready = 0 in two cases: filter row while state RUN; ifmap row with in_timestep==mac_ts while RUN. Otherwise 1.
//  - Accepted row: filt_we or ifmap_we, waddr/wbank and wdata are registered, valid for one cycle after the accept edge. Latency 1.
//  - Row index 3: accepted and dropped, no write, err[0] set.
//  - Row already present in its mask: overwrite (write issued), err[1] set.
//  - Masks: filter 3b; ifmap bank0/bank1 3b each. Accepted row sets its bit.
//  - FSM IDLE: if filt_mask==111 and ifmap_mask[exp_ts]==111 (registered state), go RUN. On the same edge set mac_start=1 and mac_ts=exp_ts.
//    - Row completing a bank at edge t: mac_start high after edge t+1.
//  - FSM RUN: mac_start drops after 1 cycle. On mac_done: clear ifmap_mask[mac_ts], toggle exp_ts, done_cnt++ (wraps at 2^CNT_W), return to IDLE.
//  - mac_done outside RUN: ignored, err[2] set.
//  - mac_done and an accept to the other bank in the same cycle: both take effect.
//  - cfg_filter_clear in IDLE: filt_mask<=0 next edge. In RUN: latched pending, applied on the edge that returns to IDLE.
//    - Clear and filter-row accept in the same IDLE cycle: clear wins; row written but bit not set.
//  - Banks out of order: bank 1 full while exp_ts=0 waits; no start until bank 0 full.
//  - rst_n low mid-RUN: immediate return to reset values; MAC result discarded by system.
// STRUCTURE
//  - pe_pkg: typedef pe_row_t (3*FILTER_WIDTH); enum sched_state_e {IDLE,RUN}; localparams ROW_MAX=2, ROW_ILLEGAL=2'd3, ERR_* bit indices.
//  - Sub-module pe_row_mask: 3b mask with set(idx), clr, full, dup outputs.
//    - Instantiated 3x: filter, ifmap bank0, ifmap bank1.
//  - Top holds FSM, ready logic, output regs, counter, sticky errors.
// TESTING
//  - Reset then 3 filter rows (0,1,2) + 3 ifmap rows ts0.
//    -> writes 1 cycle after each accept; mac_start 1 cycle, mac_ts=0, 2 cycles after last accept.
//  - During RUN(ts0): filter row offered -> in_ready=0 held. ifmap ts0 row -> in_ready=0. ifmap ts1 row -> accepted, ifmap_wbank=1.
//  - Fill bank1 during RUN(ts0), then mac_done.
//    -> done_cnt=1, exp_ts=1; mac_start with mac_ts=1 follows without new packets.
//  - filter_row=3 -> no write, err=3'b001. Resend row 0 twice -> err=3'b011.
//    - mac_done in IDLE -> err=3'b111, done_cnt unchanged.
//  - cfg_filter_clear during RUN -> filt_mask still 111 until mac_done, then 0; no further mac_start until 3 filter rows reloaded.
//  - rst_n pulsed low mid-RUN -> all outputs 0 asynchronously; after release, bank1-only load produces no start.

Source files
------------

// File: rtl/pe_load_scheduler_pkg.sv
// Shared types and constants for the PE load scheduler.
// Row payloads, FSM states and error bit positions.
package pe_load_scheduler_pkg;

  localparam int FILTER_WIDTH = 8;

  typedef logic [3*FILTER_WIDTH-1:0] pe_row_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  localparam logic [1:0] ROW_MAX     = 2'd2;
  localparam logic [1:0] ROW_ILLEGAL = 2'd3;

  localparam int ERR_BAD_ROW  = 0;
  localparam int ERR_DUP_ROW  = 1;
  localparam int ERR_SPURIOUS = 2;

endpackage

// File: rtl/pe_load_scheduler_row_mask.sv
// Three-row presence mask: set by index, bulk clear, full and duplicate flags.
// Clear takes priority over a same-cycle set.
module pe_row_mask
  import pe_load_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_i,
  input  logic [1:0] idx_i,
  input  logic       clr_i,
  output logic       full_o,
  output logic       dup_o
);

  logic [2:0] mask_q, mask_d;
  logic [3:0] mask_ext;

  assign mask_ext = {1'b0, mask_q};
  assign full_o   = &mask_q;
  assign dup_o    = (idx_i <= ROW_MAX) & mask_ext[idx_i];

  always_comb begin
    mask_d = mask_q;
    if (clr_i) begin
      mask_d = 3'b000;
    end else if (set_i && idx_i <= ROW_MAX) begin
      mask_d = mask_q | (3'b001 << idx_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= 3'b000;
    else        mask_q <= mask_d;
  end

endmodule

// File: rtl/pe_load_scheduler.sv
// Steers depacketized rows into filter / ifmap buffers and fires the MAC
// once filter and the expected timestep's ifmap bank are complete.
module pe_load_scheduler
  import pe_load_scheduler_pkg::*;
#(
  parameter int FILTER_WIDTH = pe_load_scheduler_pkg::FILTER_WIDTH,
  parameter int CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_timestep,
  input  logic                      in_ifmapb_filter,
  input  logic [1:0]                in_filter_row,
  input  logic [3*FILTER_WIDTH-1:0] in_data,
  input  logic                      cfg_filter_clear,
  output logic                      filt_we,
  output logic [1:0]                filt_waddr,
  output logic                      ifmap_we,
  output logic                      ifmap_wbank,
  output logic [1:0]                ifmap_waddr,
  output logic [3*FILTER_WIDTH-1:0] wdata,
  output logic                      mac_start,
  output logic                      mac_ts,
  input  logic                      mac_done,
  output logic [CNT_W-1:0]          done_cnt,
  output logic [2:0]                err
);

  localparam int RW = 3 * FILTER_WIDTH;

  sched_state_e     state_q, state_d;
  logic             exp_ts_q, exp_ts_d;
  logic             mac_start_q, mac_start_d;
  logic             mac_ts_q, mac_ts_d;
  logic             clr_pend_q, clr_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_q, err_d;
  logic             filt_we_q, ifmap_we_q, wbank_q;
  logic [1:0]       faddr_q, iaddr_q;
  logic [RW-1:0]    wdata_q;

  logic acc, row_ok, f_set, b0_set, b1_set;
  logic f_clr, b0_clr, b1_clr, done_ok, fire;
  logic f_full, b0_full, b1_full, f_dup, b0_dup, b1_dup;

  assign in_ready = !((state_q == RUN) &&
                      (in_ifmapb_filter || (in_timestep == mac_ts_q)));
  assign acc     = in_valid & in_ready;
  assign row_ok  = (in_filter_row != ROW_ILLEGAL);
  assign f_set   = acc & in_ifmapb_filter & row_ok;
  assign b0_set  = acc & ~in_ifmapb_filter & row_ok & ~in_timestep;
  assign b1_set  = acc & ~in_ifmapb_filter & row_ok & in_timestep;
  assign done_ok = (state_q == RUN) & mac_done;
  assign b0_clr  = done_ok & ~mac_ts_q;
  assign b1_clr  = done_ok & mac_ts_q;
  // A clear seen during RUN is held until the bank is released.
  assign f_clr   = ((state_q == IDLE) & cfg_filter_clear) |
                   (done_ok & (clr_pend_q | cfg_filter_clear));
  assign fire    = (state_q == IDLE) & f_full &
                   (exp_ts_q ? b1_full : b0_full);

  pe_row_mask u_filt (
    .clk(clk), .rst_n(rst_n), .set_i(f_set), .idx_i(in_filter_row),
    .clr_i(f_clr), .full_o(f_full), .dup_o(f_dup)
  );

  pe_row_mask u_bank0 (
    .clk(clk), .rst_n(rst_n), .set_i(b0_set), .idx_i(in_filter_row),
    .clr_i(b0_clr), .full_o(b0_full), .dup_o(b0_dup)
  );

  pe_row_mask u_bank1 (
    .clk(clk), .rst_n(rst_n), .set_i(b1_set), .idx_i(in_filter_row),
    .clr_i(b1_clr), .full_o(b1_full), .dup_o(b1_dup)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire)    state_d = RUN;
      RUN:     if (mac_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mac_start_d = fire;
    mac_ts_d    = fire ? exp_ts_q : mac_ts_q;
    exp_ts_d    = exp_ts_q ^ done_ok;
    cnt_d       = cnt_q + CNT_W'(done_ok);
    clr_pend_d  = done_ok ? 1'b0 :
                  (clr_pend_q | ((state_q == RUN) & cfg_filter_clear));
    err_d       = err_q;
    if (acc && !row_ok)            err_d[ERR_BAD_ROW]  = 1'b1;
    if ((f_set & f_dup) | (b0_set & b0_dup) | (b1_set & b1_dup))
                                   err_d[ERR_DUP_ROW]  = 1'b1;
    if (mac_done && state_q != RUN) err_d[ERR_SPURIOUS] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ts_q    <= 1'b0;
      mac_start_q <= 1'b0;
      mac_ts_q    <= 1'b0;
      clr_pend_q  <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 3'b000;
      filt_we_q   <= 1'b0;
      ifmap_we_q  <= 1'b0;
      wbank_q     <= 1'b0;
      faddr_q     <= 2'd0;
      iaddr_q     <= 2'd0;
      wdata_q     <= '0;
    end else begin
      exp_ts_q    <= exp_ts_d;
      mac_start_q <= mac_start_d;
      mac_ts_q    <= mac_ts_d;
      clr_pend_q  <= clr_pend_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      filt_we_q   <= f_set;
      ifmap_we_q  <= b0_set | b1_set;
      if (f_set) faddr_q <= in_filter_row;
      if (b0_set | b1_set) begin
        iaddr_q <= in_filter_row;
        wbank_q <= in_timestep;
      end
      if (acc && row_ok) wdata_q <= in_data;
    end
  end

  assign filt_we     = filt_we_q;
  assign filt_waddr  = faddr_q;
  assign ifmap_we    = ifmap_we_q;
  assign ifmap_wbank = wbank_q;
  assign ifmap_waddr = iaddr_q;
  assign wdata       = wdata_q;
  assign mac_start   = mac_start_q;
  assign mac_ts      = mac_ts_q;
  assign done_cnt    = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pe_load_scheduler.sv
// Directed bench for pe_load_scheduler: load, double-buffer, errors,
// deferred filter clear and asynchronous reset.
module tb_pe_load_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_timestep, in_ifmapb_filter;
  logic [1:0]  in_filter_row;
  logic [23:0] in_data;
  logic        cfg_filter_clear;
  logic        filt_we, ifmap_we, ifmap_wbank, mac_start, mac_ts, mac_done;
  logic [1:0]  filt_waddr, ifmap_waddr;
  logic [23:0] wdata;
  logic [7:0]  done_cnt;
  logic [2:0]  err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pe_load_scheduler #(.FILTER_WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_timestep(in_timestep), .in_ifmapb_filter(in_ifmapb_filter),
    .in_filter_row(in_filter_row), .in_data(in_data),
    .cfg_filter_clear(cfg_filter_clear),
    .filt_we(filt_we), .filt_waddr(filt_waddr),
    .ifmap_we(ifmap_we), .ifmap_wbank(ifmap_wbank),
    .ifmap_waddr(ifmap_waddr), .wdata(wdata),
    .mac_start(mac_start), .mac_ts(mac_ts), .mac_done(mac_done),
    .done_cnt(done_cnt), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic f, input logic ts,
                      input logic [1:0] r, input logic [23:0] d);
    in_valid = 1'b1; in_ifmapb_filter = f; in_timestep = ts;
    in_filter_row = r; in_data = d;
    tick();
    in_valid = 1'b0;
    if (r == 2'd3) begin
      chk("drop_fwe", 32'(filt_we), 32'd0);
      chk("drop_iwe", 32'(ifmap_we), 32'd0);
    end else if (f) begin
      chk("fwe", 32'(filt_we), 32'd1);
      chk("faddr", 32'(filt_waddr), 32'(r));
      chk("fdata", 32'(wdata), 32'(d));
    end else begin
      chk("iwe", 32'(ifmap_we), 32'd1);
      chk("ibank", 32'(ifmap_wbank), 32'(ts));
      chk("iaddr", 32'(ifmap_waddr), 32'(r));
      chk("idata", 32'(wdata), 32'(d));
    end
  endtask

  task automatic done_pulse();
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_timestep = 1'b0;
    in_ifmapb_filter = 1'b0; in_filter_row = 2'd0; in_data = '0;
    cfg_filter_clear = 1'b0; mac_done = 1'b0;
    #12;
    chk("rst_start", 32'(mac_start), 32'd0);
    chk("rst_cnt", 32'(done_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'({filt_we, ifmap_we}), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 2'(i), 24'hF00000 + 24'(i));
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 2'(i), 24'hA00000 + 24'(i));
    chk("start_early", 32'(mac_start), 32'd0);
    tick();
    chk("start0", 32'(mac_start), 32'd1);
    chk("start0_ts", 32'(mac_ts), 32'd0);
    tick();
    chk("start0_drop", 32'(mac_start), 32'd0);

    in_valid = 1'b1; in_ifmapb_filter = 1'b1; in_filter_row = 2'd0;
    #1 chk("rdy_filt_run", 32'(in_ready), 32'd0);
    tick();
    chk("rdy_filt_hold", 32'(in_ready), 32'd0);
    chk("no_fwe_run", 32'(filt_we), 32'd0);
    in_ifmapb_filter = 1'b0; in_timestep = 1'b0;
    #1 chk("rdy_ts0_run", 32'(in_ready), 32'd0);
    in_timestep = 1'b1;
    #1 chk("rdy_ts1_run", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 2'(i), 24'hB00000 + 24'(i));

    done_pulse();
    chk("cnt1", 32'(done_cnt), 32'd1);
    chk("no_start_yet", 32'(mac_start), 32'd0);
    tick();
    chk("start1", 32'(mac_start), 32'd1);
    chk("start1_ts", 32'(mac_ts), 32'd1);
    tick();
    done_pulse();
    chk("cnt2", 32'(done_cnt), 32'd2);
    tick();
    chk("idle_no_start", 32'(mac_start), 32'd0);

    send(1'b0, 1'b0, 2'd3, 24'h123456);
    chk("err_bad", 32'(err), 32'b001);
    send(1'b0, 1'b0, 2'd0, 24'hC00000);
    chk("err_first0", 32'(err), 32'b001);
    send(1'b0, 1'b0, 2'd0, 24'hC00001);
    chk("err_dup", 32'(err), 32'b011);
    done_pulse();
    chk("err_spur", 32'(err), 32'b111);
    chk("cnt_spur", 32'(done_cnt), 32'd2);

    send(1'b0, 1'b0, 2'd1, 24'hC00011);
    send(1'b0, 1'b0, 2'd2, 24'hC00022);
    chk("start2_early", 32'(mac_start), 32'd0);
    tick();
    chk("start2", 32'(mac_start), 32'd1);
    chk("start2_ts", 32'(mac_ts), 32'd0);
    cfg_filter_clear = 1'b1;
    tick();
    cfg_filter_clear = 1'b0;
    done_pulse();
    chk("cnt3", 32'(done_cnt), 32'd3);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 2'(i), 24'hD00000 + 24'(i));
    tick();
    tick();
    chk("clr_no_start", 32'(mac_start), 32'd0);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 2'(i), 24'hE00000 + 24'(i));
    chk("reload_early", 32'(mac_start), 32'd0);
    tick();
    chk("reload_start", 32'(mac_start), 32'd1);
    chk("reload_ts", 32'(mac_ts), 32'd1);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", 32'(mac_start), 32'd0);
    chk("arst_ts", 32'(mac_ts), 32'd0);
    chk("arst_cnt", 32'(done_cnt), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_data", 32'(wdata), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 2'(i), 24'h100000 + 24'(i));
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 2'(i), 24'h200000 + 24'(i));
    tick();
    chk("b1only_a", 32'(mac_start), 32'd0);
    tick();
    chk("b1only_b", 32'(mac_start), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
